alu_rs: RTL and testbench

- Reservation station and issue scheduler for the single integer ALU.
- Buffers up to RS_SIZE dispatched ALU/branch-compare micro-ops and tracks pending source operands by ROB id.
- Captures operand values from the two result broadcast buses (ALU, load/store buffer).
- Each cycle selects at most one operand-complete entry and drives it into the ALU issue interface.

---
 rtl/alu_rs_if.sv | 47 ++++
 rtl/alu_rs.sv | 129 ++++++++++++
 tb/tb_alu_rs.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_rs_if.sv
// Dispatch, result-broadcast and ALU-issue signals of the ALU reservation station.
// The master modport is the surrounding core; the slave modport is the station itself.
interface alu_rs_if #(
  parameter int XLEN           = 32,
  parameter int ROB_SIZE_WIDTH = 4,
  parameter int ALU_OP_WIDTH   = 4
) ();
  logic                      flush;

  logic                      dec_valid;
  logic [ALU_OP_WIDTH-1:0]   dec_op;
  logic [XLEN-1:0]           dec_val1;
  logic                      dec_q1_busy;
  logic [ROB_SIZE_WIDTH-1:0] dec_q1;
  logic [XLEN-1:0]           dec_val2;
  logic                      dec_q2_busy;
  logic [ROB_SIZE_WIDTH-1:0] dec_q2;
  logic [ROB_SIZE_WIDTH-1:0] dec_id;
  logic                      rs_full;

  logic                      alu_ready;
  logic [XLEN-1:0]           alu_res;
  logic [ROB_SIZE_WIDTH-1:0] alu_id;
  logic                      lsb_ready;
  logic [XLEN-1:0]           lsb_res;
  logic [ROB_SIZE_WIDTH-1:0] lsb_id;

  logic                      rs_ready;
  logic [ALU_OP_WIDTH-1:0]   rs_op;
  logic [XLEN-1:0]           rs_val1;
  logic [XLEN-1:0]           rs_val2;
  logic [ROB_SIZE_WIDTH-1:0] rs_id;

  modport master (
    output flush, dec_valid, dec_op, dec_val1, dec_q1_busy, dec_q1,
           dec_val2, dec_q2_busy, dec_q2, dec_id,
           alu_ready, alu_res, alu_id, lsb_ready, lsb_res, lsb_id,
    input  rs_full, rs_ready, rs_op, rs_val1, rs_val2, rs_id
  );

  modport slave (
    input  flush, dec_valid, dec_op, dec_val1, dec_q1_busy, dec_q1,
           dec_val2, dec_q2_busy, dec_q2, dec_id,
           alu_ready, alu_res, alu_id, lsb_ready, lsb_res, lsb_id,
    output rs_full, rs_ready, rs_op, rs_val1, rs_val2, rs_id
  );
endinterface

// File: rtl/alu_rs.sv
// ALU reservation station: dispatch-to-issue one edge after operands are complete, one issue per cycle.
// Back-pressure is rs_full only (dispatch while full is ignored); the ALU never stalls issue.
module alu_rs #(
  parameter int RS_SIZE        = 8,
  parameter int RS_SIZE_WIDTH  = 3,
  parameter int XLEN           = 32,
  parameter int ROB_SIZE_WIDTH = 4,
  parameter int ALU_OP_WIDTH   = 4
) (
  input logic    clk,
  input logic    rst_n,
  alu_rs_if.slave bus
);

  typedef struct packed {
    logic                      busy;
    logic [ALU_OP_WIDTH-1:0]   op;
    logic [XLEN-1:0]           val1;
    logic                      q1_busy;
    logic [ROB_SIZE_WIDTH-1:0] q1;
    logic [XLEN-1:0]           val2;
    logic                      q2_busy;
    logic [ROB_SIZE_WIDTH-1:0] q2;
    logic [ROB_SIZE_WIDTH-1:0] id;
  } entry_t;

  entry_t                   ent [RS_SIZE];
  entry_t                   new_ent;
  logic                     full;
  logic                     has_iss;
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic [RS_SIZE_WIDTH-1:0] iss_idx;

  // Downward scan so the lowest index wins for both free slot and issue pick.
  always_comb begin
    full     = 1'b1;
    has_iss  = 1'b0;
    free_idx = '0;
    iss_idx  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!ent[i].busy) begin
        full     = 1'b0;
        free_idx = RS_SIZE_WIDTH'(i);
      end
      if (ent[i].busy && !ent[i].q1_busy && !ent[i].q2_busy) begin
        has_iss = 1'b1;
        iss_idx = RS_SIZE_WIDTH'(i);
      end
    end
  end

  assign bus.rs_full = full;

  // Incoming entry, with same-cycle capture from either broadcast bus.
  always_comb begin
    new_ent         = '0;
    new_ent.busy    = 1'b1;
    new_ent.op      = bus.dec_op;
    new_ent.id      = bus.dec_id;
    new_ent.val1    = bus.dec_val1;
    new_ent.q1_busy = bus.dec_q1_busy;
    new_ent.q1      = bus.dec_q1;
    new_ent.val2    = bus.dec_val2;
    new_ent.q2_busy = bus.dec_q2_busy;
    new_ent.q2      = bus.dec_q2;
    if (bus.dec_q1_busy && bus.alu_ready && bus.alu_id == bus.dec_q1) begin
      new_ent.val1    = bus.alu_res;
      new_ent.q1_busy = 1'b0;
    end else if (bus.dec_q1_busy && bus.lsb_ready && bus.lsb_id == bus.dec_q1) begin
      new_ent.val1    = bus.lsb_res;
      new_ent.q1_busy = 1'b0;
    end
    if (bus.dec_q2_busy && bus.alu_ready && bus.alu_id == bus.dec_q2) begin
      new_ent.val2    = bus.alu_res;
      new_ent.q2_busy = 1'b0;
    end else if (bus.dec_q2_busy && bus.lsb_ready && bus.lsb_id == bus.dec_q2) begin
      new_ent.val2    = bus.lsb_res;
      new_ent.q2_busy = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      bus.rs_ready <= 1'b0;
      bus.rs_op    <= '0;
      bus.rs_val1  <= '0;
      bus.rs_val2  <= '0;
      bus.rs_id    <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
      bus.rs_ready <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (ent[i].busy && ent[i].q1_busy) begin
          if (bus.alu_ready && bus.alu_id == ent[i].q1) begin
            ent[i].val1    <= bus.alu_res;
            ent[i].q1_busy <= 1'b0;
          end else if (bus.lsb_ready && bus.lsb_id == ent[i].q1) begin
            ent[i].val1    <= bus.lsb_res;
            ent[i].q1_busy <= 1'b0;
          end
        end
        if (ent[i].busy && ent[i].q2_busy) begin
          if (bus.alu_ready && bus.alu_id == ent[i].q2) begin
            ent[i].val2    <= bus.alu_res;
            ent[i].q2_busy <= 1'b0;
          end else if (bus.lsb_ready && bus.lsb_id == ent[i].q2) begin
            ent[i].val2    <= bus.lsb_res;
            ent[i].q2_busy <= 1'b0;
          end
        end
      end

      bus.rs_ready <= has_iss;
      if (has_iss) begin
        ent[iss_idx].busy <= 1'b0;
        bus.rs_op         <= ent[iss_idx].op;
        bus.rs_val1       <= ent[iss_idx].val1;
        bus.rs_val2       <= ent[iss_idx].val2;
        bus.rs_id         <= ent[iss_idx].id;
      end

      // free_idx is never the issuing entry, so a freed slot waits one edge.
      if (bus.dec_valid && !full) ent[free_idx] <= new_ent;
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed plus random bench for alu_rs against a slot-list reference model.
module tb_alu_rs;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_rs_if #(.XLEN(32), .ROB_SIZE_WIDTH(4), .ALU_OP_WIDTH(4)) rif ();

  alu_rs #(.RS_SIZE(8), .RS_SIZE_WIDTH(3), .XLEN(32), .ROB_SIZE_WIDTH(4), .ALU_OP_WIDTH(4))
    dut (.clk(clk), .rst_n(rst_n), .bus(rif.slave));

  typedef struct {
    bit         busy;
    bit         w1, w2;        // still waiting for operand
    logic [3:0] op, q1, q2, id;
    logic [31:0] v1, v2;
  } slot_t;

  slot_t       m [8];
  bit          e_rdy;
  logic [3:0]  e_op, e_id;
  logic [31:0] e_v1, e_v2;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m[i].busy = 0;
    e_rdy = 0; e_op = 0; e_id = 0; e_v1 = 0; e_v2 = 0;
  endtask

  // Returns the value a waiting operand picks up from this cycle's broadcasts, if any.
  task automatic snoop(input logic [3:0] q, inout bit waiting, inout logic [31:0] v);
    if (!waiting) return;
    if (rif.alu_ready && rif.alu_id == q) begin v = rif.alu_res; waiting = 0; end
    else if (rif.lsb_ready && rif.lsb_id == q) begin v = rif.lsb_res; waiting = 0; end
  endtask

  task automatic model_edge();
    slot_t old [8];
    int    fr, is;
    if (rif.flush) begin
      for (int i = 0; i < 8; i++) m[i].busy = 0;
      e_rdy = 0;
      return;
    end
    old = m; fr = -1; is = -1;
    for (int i = 0; i < 8; i++) begin
      if (!old[i].busy && fr < 0) fr = i;
      if (old[i].busy && !old[i].w1 && !old[i].w2 && is < 0) is = i;
    end
    e_rdy = (is >= 0);
    if (is >= 0) begin
      e_op = old[is].op; e_v1 = old[is].v1; e_v2 = old[is].v2; e_id = old[is].id;
      m[is].busy = 0;
    end
    for (int i = 0; i < 8; i++)
      if (old[i].busy) begin
        snoop(m[i].q1, m[i].w1, m[i].v1);
        snoop(m[i].q2, m[i].w2, m[i].v2);
      end
    if (rif.dec_valid && fr >= 0) begin
      m[fr].busy = 1; m[fr].op = rif.dec_op; m[fr].id = rif.dec_id;
      m[fr].w1 = rif.dec_q1_busy; m[fr].q1 = rif.dec_q1; m[fr].v1 = rif.dec_val1;
      m[fr].w2 = rif.dec_q2_busy; m[fr].q2 = rif.dec_q2; m[fr].v2 = rif.dec_val2;
      snoop(m[fr].q1, m[fr].w1, m[fr].v1);
      snoop(m[fr].q2, m[fr].w2, m[fr].v2);
    end
  endtask

  function automatic bit model_full();
    for (int i = 0; i < 8; i++) if (!m[i].busy) return 0;
    return 1;
  endfunction

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".rdy"}, 32'(rif.rs_ready), 32'(e_rdy));
    chk({tag, ".full"}, 32'(rif.rs_full), 32'(model_full()));
    if (e_rdy) begin
      chk({tag, ".op"}, 32'(rif.rs_op), 32'(e_op));
      chk({tag, ".v1"}, rif.rs_val1, e_v1);
      chk({tag, ".v2"}, rif.rs_val2, e_v2);
      chk({tag, ".id"}, 32'(rif.rs_id), 32'(e_id));
    end
  endtask

  task automatic clr();
    rif.flush = 0; rif.dec_valid = 0; rif.alu_ready = 0; rif.lsb_ready = 0;
    rif.dec_q1_busy = 0; rif.dec_q2_busy = 0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [31:0] v1, input bit b1, input logic [3:0] q1,
                      input logic [31:0] v2, input bit b2, input logic [3:0] q2, input logic [3:0] id);
    rif.dec_valid = 1; rif.dec_op = op; rif.dec_id = id;
    rif.dec_val1 = v1; rif.dec_q1_busy = b1; rif.dec_q1 = q1;
    rif.dec_val2 = v2; rif.dec_q2_busy = b2; rif.dec_q2 = q2;
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 0;
    #1;
    chk({tag, ".rdy"}, 32'(rif.rs_ready), 0);
    chk({tag, ".full"}, 32'(rif.rs_full), 0);
    chk({tag, ".op"}, 32'(rif.rs_op), 0);
    model_reset();
    clr();
    @(negedge clk) rst_n = 1;
  endtask

  initial begin
    clr();
    rif.dec_op = 0; rif.dec_val1 = 0; rif.dec_q1 = 0; rif.dec_val2 = 0; rif.dec_q2 = 0; rif.dec_id = 0;
    rif.alu_res = 0; rif.alu_id = 0; rif.lsb_res = 0; rif.lsb_id = 0;
    model_reset();
    #12;
    chk("rst.rdy", 32'(rif.rs_ready), 0);
    chk("rst.full", 32'(rif.rs_full), 0);
    chk("rst.v1", rif.rs_val1, 0);
    chk("rst.id", 32'(rif.rs_id), 0);
    @(negedge clk) rst_n = 1;

    // ADD 5+7 ready at dispatch
    disp(4'd0, 32'd5, 0, 4'd0, 32'd7, 0, 4'd0, 4'd3); tick("add.disp"); clr();
    tick("add.issue");
    chk("add.v1", rif.rs_val1, 32'd5);
    chk("add.id", 32'(rif.rs_id), 32'd3);
    tick("add.idle");

    // SUB waiting on ROB 6, woken by the ALU bus
    disp(4'd1, 32'd0, 1, 4'd6, 32'd1, 0, 4'd0, 4'd2); tick("sub.disp"); clr();
    for (int i = 0; i < 3; i++) tick("sub.wait");
    rif.alu_ready = 1; rif.alu_id = 4'd6; rif.alu_res = 32'd100; tick("sub.wake"); clr();
    tick("sub.issue");
    chk("sub.v1", rif.rs_val1, 32'd100);

    // dispatch bypass from the LSB bus
    rif.lsb_ready = 1; rif.lsb_id = 4'd9; rif.lsb_res = 32'hdead;
    disp(4'd2, 32'd1, 0, 4'd0, 32'd0, 1, 4'd9, 4'd4); tick("byp.disp"); clr();
    tick("byp.issue");
    chk("byp.v2", rif.rs_val2, 32'hdead);

    // fill, ignored extra dispatch, wake entry 5
    for (int i = 0; i < 8; i++) begin
      disp(4'(i), 32'd0, 1, 4'(8 + i), 32'(i), 0, 4'd0, 4'(i)); tick("fill"); clr();
    end
    chk("fill.full", 32'(rif.rs_full), 1);
    disp(4'd7, 32'd1, 0, 4'd0, 32'd1, 0, 4'd0, 4'd15); tick("full.ign"); clr();
    rif.alu_ready = 1; rif.alu_id = 4'd13; rif.alu_res = 32'd55; tick("e5.wake"); clr();
    tick("e5.issue");
    chk("e5.id", 32'(rif.rs_id), 32'd5);
    chk("e5.full", 32'(rif.rs_full), 0);
    rif.flush = 1; tick("flush0"); clr();

    // entries 1 and 4 woken together
    for (int i = 0; i < 6; i++) begin
      disp(4'd3, 32'd0, 1, 4'(8 + i), 32'(i), 0, 4'd0, 4'(i)); tick("pr.fill"); clr();
    end
    rif.alu_ready = 1; rif.alu_id = 4'd9; rif.alu_res = 32'd11;
    rif.lsb_ready = 1; rif.lsb_id = 4'd12; rif.lsb_res = 32'd44;
    tick("pr.wake"); clr();
    tick("pr.first");  chk("pr.first.id", 32'(rif.rs_id), 32'd1);
    tick("pr.second"); chk("pr.second.id", 32'(rif.rs_id), 32'd4);

    // flush while issuing, with a dispatch in the same cycle
    disp(4'd4, 32'd1, 0, 4'd0, 32'd2, 0, 4'd0, 4'd7); tick("fl.d0");
    disp(4'd5, 32'd3, 0, 4'd0, 32'd4, 0, 4'd0, 4'd8); tick("fl.d1");
    chk("fl.pre.rdy", 32'(rif.rs_ready), 1);
    rif.flush = 1; tick("fl.edge"); clr();
    chk("fl.rdy", 32'(rif.rs_ready), 0);
    chk("fl.full", 32'(rif.rs_full), 0);
    for (int i = 0; i < 3; i++) tick("fl.quiet");

    // asynchronous reset while full, then while issuing
    for (int i = 0; i < 8; i++) begin
      disp(4'd6, 32'd0, 1, 4'(8 + i), 32'd0, 0, 4'd0, 4'(i)); tick("rf.fill"); clr();
    end
    chk("rf.full", 32'(rif.rs_full), 1);
    async_reset("arst.full");
    disp(4'd6, 32'd9, 0, 4'd0, 32'd9, 0, 4'd0, 4'd1); tick("ri.disp"); clr();
    tick("ri.issue");
    chk("ri.rdy", 32'(rif.rs_ready), 1);
    async_reset("arst.issue");

    // random traffic
    for (int c = 0; c < 600; c++) begin
      clr();
      rif.flush = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 1) == 1)
        disp(4'($urandom), $urandom, bit'($urandom_range(0, 1)), 4'($urandom),
             $urandom, bit'($urandom_range(0, 1)), 4'($urandom), 4'($urandom));
      rif.alu_ready = bit'($urandom_range(0, 1)); rif.alu_id = 4'($urandom); rif.alu_res = $urandom;
      rif.lsb_ready = bit'($urandom_range(0, 1)); rif.lsb_id = 4'($urandom); rif.lsb_res = $urandom;
      if (rif.lsb_id == rif.alu_id) rif.lsb_id = rif.lsb_id ^ 4'd1;
      tick("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
